rv32i_lsu: RTL

Load/store unit controller for the rv32i core. It accepts one LOAD or STORE operation at a time from the execute stage, decoded by funct3 per the LB/LH/LW/LBU/LHU and SB/SH/SW encodings. It checks alignment, drives a single-outstanding request/grant/rvalid data-memory bus with byte enables, and returns a sign- or zero-extended writeback result. It sits between the execute stage and the data memory, and stalls the pipeline through its ready/valid handshakes.

---
 rtl/rv32i_lsu.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rv32i_lsu.sv
// rv32i load/store unit: one outstanding LOAD/STORE, alignment/funct3 checking,
// request/grant/rvalid data bus with byte enables, extended writeback result.
module rv32i_lsu #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic            i_req_is_store,
   input  logic [2:0]      i_req_f3,
   input  logic [XLEN-1:0] i_req_addr,
   input  logic [XLEN-1:0] i_req_wdata,
   input  logic [4:0]      i_req_rd,
   output logic            o_mem_req,
   input  logic            i_mem_gnt,
   output logic            o_mem_we,
   output logic [3:0]      o_mem_be,
   output logic [XLEN-1:0] o_mem_addr,
   output logic [XLEN-1:0] o_mem_wdata,
   input  logic            i_mem_rvalid,
   input  logic [XLEN-1:0] i_mem_rdata,
   output logic            o_resp_valid,
   input  logic            i_resp_ready,
   output logic            o_resp_we,
   output logic [4:0]      o_resp_rd,
   output logic [XLEN-1:0] o_resp_data,
   output logic            o_resp_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t          r_state;
   logic            r_is_store;
   logic [2:0]      r_f3;
   logic [1:0]      r_off;

   logic            w_accept;
   logic [1:0]      w_off;
   logic            w_f3_illegal;
   logic            w_misalign;
   logic            w_err;
   logic [3:0]      w_be;
   logic [XLEN-1:0] w_wdata;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [XLEN-1:0] w_ldata;

   assign o_req_ready = (r_state == S_IDLE);
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_off       = i_req_addr[1:0];

   // funct3[1:0] encodes the access size for both loads and stores
   assign w_f3_illegal = i_req_is_store ? (i_req_f3 > 3'b010)
                                        : (i_req_f3 == 3'b011 || i_req_f3[2:1] == 2'b11);
   assign w_misalign   = (i_req_f3[1:0] == 2'b01 && w_off[0]) ||
                         (i_req_f3[1:0] == 2'b10 && w_off != 2'b00);
   assign w_err        = w_f3_illegal || w_misalign;

   // Lane-replicated store data and byte enables
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_req_wdata;
      case (i_req_f3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{i_req_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << w_off;
            w_wdata = {2{i_req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load lane select and extension
   assign w_byte = i_mem_rdata[{r_off, 3'b000} +: 8];
   assign w_half = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

   always_comb begin
      w_ldata = i_mem_rdata;
      case (r_f3)
         3'b000:  w_ldata = {{(XLEN-8){w_byte[7]}}, w_byte};
         3'b100:  w_ldata = {{(XLEN-8){1'b0}}, w_byte};
         3'b001:  w_ldata = {{(XLEN-16){w_half[15]}}, w_half};
         3'b101:  w_ldata = {{(XLEN-16){1'b0}}, w_half};
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_is_store   <= 1'b0;
         r_f3         <= 3'b000;
         r_off        <= 2'b00;
         o_mem_req    <= 1'b0;
         o_mem_we     <= 1'b0;
         o_mem_be     <= 4'b0000;
         o_mem_addr   <= '0;
         o_mem_wdata  <= '0;
         o_resp_valid <= 1'b0;
         o_resp_we    <= 1'b0;
         o_resp_rd    <= 5'd0;
         o_resp_data  <= '0;
         o_resp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_is_store <= i_req_is_store;
                  r_f3       <= i_req_f3;
                  r_off      <= w_off;
                  o_resp_rd  <= i_req_rd;
                  if (w_err) begin
                     r_state      <= S_RESP;
                     o_resp_valid <= 1'b1;
                     o_resp_err   <= 1'b1;
                     o_resp_we    <= 1'b0;
                     o_resp_data  <= '0;
                  end else begin
                     r_state     <= S_REQ;
                     o_mem_req   <= 1'b1;
                     o_mem_we    <= i_req_is_store;
                     o_mem_be    <= w_be;
                     o_mem_addr  <= {i_req_addr[XLEN-1:2], 2'b00};
                     o_mem_wdata <= w_wdata;
                  end
               end
            end
            S_REQ: begin
               if (i_mem_gnt) begin
                  r_state   <= S_WAIT;
                  o_mem_req <= 1'b0;
               end
            end
            S_WAIT: begin
               if (i_mem_rvalid) begin
                  r_state      <= S_RESP;
                  o_resp_valid <= 1'b1;
                  o_resp_err   <= 1'b0;
                  o_resp_we    <= !r_is_store;
                  o_resp_data  <= r_is_store ? '0 : w_ldata;
               end
            end
            S_RESP: begin
               if (i_resp_ready) begin
                  r_state      <= S_IDLE;
                  o_resp_valid <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
